// File: rtl/sram_arb_pkg.sv
// Shared types and default widths for the single-SRAM two-port arbiter.
package sram_arb_pkg;

  localparam int unsigned DEF_ADDR_W = 20;
  localparam int unsigned DEF_DATA_W = 16;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_ACK
  } state_t;

  typedef enum logic {
    GNT_A,
    GNT_B
  } grant_t;

endpackage

// File: rtl/sram_arbiter.sv
// Arbitrates a read/write port A and a read-only port B onto one asynchronous SRAM,
// sequencing strobe timing and bounding how long B can be starved by A.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = DEF_ADDR_W,
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned ACCESS_CYC = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_a_req,
  input  logic              i_a_we,
  input  logic [ADDR_W-1:0] i_a_addr,
  input  logic [DATA_W-1:0] i_a_wdata,
  output logic              o_a_ack,
  output logic [DATA_W-1:0] o_a_rdata,
  input  logic              i_b_req,
  input  logic [ADDR_W-1:0] i_b_addr,
  output logic              o_b_ack,
  output logic [DATA_W-1:0] o_b_rdata,
  output logic [ADDR_W-1:0] o_SRAM_ADDR,
  inout  wire  [DATA_W-1:0] io_SRAM_DQ,
  output logic              o_SRAM_WE_N,
  output logic              o_SRAM_CE_N,
  output logic              o_SRAM_OE_N,
  output logic              o_SRAM_LB_N,
  output logic              o_SRAM_UB_N,
  output logic              o_busy
);

  localparam int unsigned SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  localparam logic [SW-1:0] STARVE_SAT = SW'(STARVE_MAX);
  localparam logic [3:0]    CNT_LOAD   = 4'(ACCESS_CYC - 1);

  state_t            state_q, state_d;
  grant_t            gnt_q, gnt_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [SW-1:0]     starve_q, starve_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] a_rdata_q, a_rdata_d;
  logic [DATA_W-1:0] b_rdata_q, b_rdata_d;
  logic              a_ack_q, a_ack_d;
  logic              b_ack_q, b_ack_d;
  logic              ce_n_q, ce_n_d;
  logic              oe_n_q, oe_n_d;
  logic              we_n_q, we_n_d;
  logic              dq_oe_q, dq_oe_d;
  logic              busy_q, busy_d;
  logic              in_access_d;

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    cnt_d     = cnt_q;
    starve_d  = starve_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    a_rdata_d = a_rdata_q;
    b_rdata_d = b_rdata_q;
    a_ack_d   = 1'b0;
    b_ack_d   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (!i_b_req) begin
          starve_d = '0;
        end
        if (i_a_req || i_b_req) begin
          // A wins ties until B has waited through STARVE_MAX A grants; the
          // increment can never pass the limit because B is granted there instead.
          if (i_a_req && !(i_b_req && (starve_q == STARVE_SAT))) begin
            gnt_d   = GNT_A;
            we_d    = i_a_we;
            addr_d  = i_a_addr;
            wdata_d = i_a_wdata;
            if (i_b_req) begin
              starve_d = starve_q + 1'b1;
            end
          end else begin
            gnt_d    = GNT_B;
            we_d     = 1'b0;
            addr_d   = i_b_addr;
            starve_d = '0;
          end
          cnt_d   = CNT_LOAD;
          state_d = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (cnt_q == 4'd0) begin
          if (!we_q) begin
            if (gnt_q == GNT_A) begin
              a_rdata_d = io_SRAM_DQ;
            end else begin
              b_rdata_d = io_SRAM_DQ;
            end
          end
          a_ack_d = (gnt_q == GNT_A);
          b_ack_d = (gnt_q == GNT_B);
          state_d = S_ACK;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_ACK: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Strobes are decoded from next state so they come straight off flops.
    // WE_N rises one cycle before the strobes drop to give data/address hold.
    in_access_d = (state_d == S_ACCESS);
    ce_n_d      = !in_access_d;
    oe_n_d      = !(in_access_d && !we_d);
    we_n_d      = !(in_access_d && we_d && (cnt_d != 4'd0));
    dq_oe_d     = in_access_d && we_d;
    busy_d      = (state_d != S_IDLE);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= S_IDLE;
      gnt_q     <= GNT_A;
      cnt_q     <= '0;
      starve_q  <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      a_rdata_q <= '0;
      b_rdata_q <= '0;
      a_ack_q   <= 1'b0;
      b_ack_q   <= 1'b0;
      ce_n_q    <= 1'b1;
      oe_n_q    <= 1'b1;
      we_n_q    <= 1'b1;
      dq_oe_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      cnt_q     <= cnt_d;
      starve_q  <= starve_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      a_rdata_q <= a_rdata_d;
      b_rdata_q <= b_rdata_d;
      a_ack_q   <= a_ack_d;
      b_ack_q   <= b_ack_d;
      ce_n_q    <= ce_n_d;
      oe_n_q    <= oe_n_d;
      we_n_q    <= we_n_d;
      dq_oe_q   <= dq_oe_d;
      busy_q    <= busy_d;
    end
  end

  assign io_SRAM_DQ  = dq_oe_q ? wdata_q : {DATA_W{1'bz}};
  assign o_SRAM_ADDR = addr_q;
  assign o_SRAM_CE_N = ce_n_q;
  assign o_SRAM_LB_N = ce_n_q;
  assign o_SRAM_UB_N = ce_n_q;
  assign o_SRAM_OE_N = oe_n_q;
  assign o_SRAM_WE_N = we_n_q;
  assign o_a_ack     = a_ack_q;
  assign o_b_ack     = b_ack_q;
  assign o_a_rdata   = a_rdata_q;
  assign o_b_rdata   = b_rdata_q;
  assign o_busy      = busy_q;

endmodule
